// File: rtl/note_pkg.sv
// Shared types, codes and helpers for the polyphonic note generator.
package note_pkg;

  typedef enum logic [1:0] {
    ENV_IDLE,
    ENV_ATTACK,
    ENV_SUSTAIN,
    ENV_RELEASE
  } env_state_t;

  localparam logic [1:0] MODE_SQ50  = 2'b00;
  localparam logic [1:0] MODE_SQ12  = 2'b01;
  localparam logic [1:0] MODE_NOISE = 2'b10;
  localparam logic [1:0] MODE_MUTE  = 2'b11;

  // Pan codes 00 and 11 both feed the two sides.
  localparam logic [1:0] PAN_LEFT  = 2'b01;
  localparam logic [1:0] PAN_RIGHT = 2'b10;

  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0].
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int         VOL_STEP = 1024;
  localparam logic [3:0] ENV_MAX  = 4'd15;

  function automatic logic signed [15:0] sat16(input logic signed [31:0] v);
    if (v > 32'sd32767)
      return 16'sh7FFF;
    else if (v < -32'sd32768)
      return 16'sh8000;
    else
      return v[15:0];
  endfunction

endpackage

// File: rtl/note_channel.sv
// One voice: phase divider, duty/noise waveform, ASR envelope and signed
// contribution to the mixer.
module note_channel
  import note_pkg::*;
#(
  parameter int DIV_W = 22
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    noise_bit,
  input  logic [DIV_W-1:0]        note_div,
  input  logic                    gate,
  input  logic [1:0]              mode,
  input  logic [2:0]              volume,
  output logic signed [16:0]      contrib
);

  logic [DIV_W-1:0] cnt;
  logic             rest;
  logic             wrap;
  logic             noise_sign;
  logic             high;
  env_state_t       state, state_next;
  logic [3:0]       env, env_next;
  logic [12:0]      amp;

  assign rest = (note_div <= DIV_W'(1));
  // A shrinking divider below the current count also counts as a wrap.
  assign wrap = !rest && (cnt >= note_div - DIV_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      noise_sign <= 1'b0;
      state      <= ENV_IDLE;
      env        <= 4'd0;
    end else begin
      if (rest || wrap)
        cnt <= '0;
      else
        cnt <= cnt + DIV_W'(1);
      if (wrap)
        noise_sign <= noise_bit;
      state <= state_next;
      env   <= env_next;
    end
  end

  always_comb begin
    high = 1'b0;
    case (mode)
      MODE_SQ50:  high = (cnt < (note_div >> 1));
      MODE_SQ12:  high = (cnt < (note_div >> 3));
      MODE_NOISE: high = noise_sign;
      default:    high = 1'b0;
    endcase
  end

  // Transitions first; a coincident tick then steps the level in the new state.
  always_comb begin
    state_next = state;
    env_next   = env;
    case (state)
      ENV_IDLE:
        if (gate) state_next = ENV_ATTACK;
      ENV_ATTACK:
        if (!gate) state_next = ENV_RELEASE;
        else if (env == ENV_MAX) state_next = ENV_SUSTAIN;
      ENV_SUSTAIN:
        if (!gate) state_next = ENV_RELEASE;
      ENV_RELEASE:
        if (gate) state_next = ENV_ATTACK;
        else if (env == 4'd0) state_next = ENV_IDLE;
      default:
        state_next = ENV_IDLE;
    endcase
    if (tick) begin
      case (state_next)
        ENV_ATTACK:  if (env != ENV_MAX) env_next = env + 4'd1;
        ENV_RELEASE: if (env != 4'd0) env_next = env - 4'd1;
        ENV_SUSTAIN: env_next = ENV_MAX;
        default:     env_next = 4'd0;
      endcase
    end
  end

  assign amp = 13'((32'(volume) * VOL_STEP * 32'(env)) >> 4);

  always_comb begin
    contrib = '0;
    if (mode != MODE_MUTE && !rest && env != 4'd0)
      contrib = high ? $signed({4'b0, amp}) : -$signed({4'b0, amp});
  end

endmodule

// File: rtl/poly_note_gen.sv
// Multi-voice note generator: shared envelope prescaler and noise LFSR,
// NUM_CH voices, and a pan-aware saturating stereo mixer.
module poly_note_gen
  import note_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int DIV_W        = 22,
  parameter int ENV_STEP_DIV = 100_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*DIV_W-1:0]   note_div,
  input  logic [NUM_CH-1:0]         gate,
  input  logic [2*NUM_CH-1:0]       mode,
  input  logic [3*NUM_CH-1:0]       volume,
  input  logic [2*NUM_CH-1:0]       pan,
  output logic signed [15:0]        audio_left,
  output logic signed [15:0]        audio_right
);

  localparam int PRE_W = (ENV_STEP_DIV > 1) ? $clog2(ENV_STEP_DIV) : 1;
  localparam int SUM_W = $clog2(NUM_CH) + 17;

  logic [PRE_W-1:0]        presc;
  logic                    tick;
  logic [15:0]             lfsr;
  logic signed [16:0]      contrib [NUM_CH];
  logic signed [SUM_W-1:0] left_sum, right_sum;

  assign tick = (presc == PRE_W'(ENV_STEP_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
      lfsr  <= LFSR_SEED;
    end else begin
      presc <= tick ? '0 : presc + PRE_W'(1);
      lfsr  <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    note_channel #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .noise_bit (lfsr[15]),
      .note_div  (note_div[i*DIV_W +: DIV_W]),
      .gate      (gate[i]),
      .mode      (mode[2*i +: 2]),
      .volume    (volume[3*i +: 3]),
      .contrib   (contrib[i])
    );
  end

  always_comb begin
    left_sum  = '0;
    right_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pan[2*i +: 2] != PAN_RIGHT)
        left_sum = left_sum + SUM_W'(contrib[i]);
      if (pan[2*i +: 2] != PAN_LEFT)
        right_sum = right_sum + SUM_W'(contrib[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      audio_left  <= '0;
      audio_right <= '0;
    end else begin
      audio_left  <= sat16(32'(left_sum));
      audio_right <= sat16(32'(right_sum));
    end
  end

endmodule

// File: tb/tb_poly_note_gen.sv
// Scoreboard bench for poly_note_gen: a behavioural reference pushes the
// expected stereo sample each cycle, compared one clock later.
module tb_poly_note_gen;

  localparam int NUM_CH = 8;
  localparam int DIV_W  = 22;
  localparam int ESD    = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH*DIV_W-1:0] note_div;
  logic [NUM_CH-1:0]       gate;
  logic [2*NUM_CH-1:0]     mode;
  logic [3*NUM_CH-1:0]     volume;
  logic [2*NUM_CH-1:0]     pan;
  logic signed [15:0]      audio_left, audio_right;

  int t_div  [NUM_CH];
  int t_mode [NUM_CH];
  int t_vol  [NUM_CH];
  int t_pan  [NUM_CH];
  bit t_gate [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign note_div[g*DIV_W +: DIV_W] = DIV_W'(t_div[g]);
    assign gate[g]                    = t_gate[g];
    assign mode[2*g +: 2]             = 2'(t_mode[g]);
    assign volume[3*g +: 3]           = 3'(t_vol[g]);
    assign pan[2*g +: 2]              = 2'(t_pan[g]);
  end

  always #5 clk = ~clk;

  poly_note_gen #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .ENV_STEP_DIV(ESD)
  ) dut (
    .clk(clk), .rst(rst), .note_div(note_div), .gate(gate), .mode(mode),
    .volume(volume), .pan(pan), .audio_left(audio_left), .audio_right(audio_right)
  );

  typedef struct { int l; int r; } exp_t;
  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model state (env states: 0 idle, 1 attack, 2 sustain, 3 release)
  int          m_cnt  [NUM_CH];
  int          m_env  [NUM_CH];
  int          m_st   [NUM_CH];
  bit          m_sign [NUM_CH];
  logic [15:0] m_lfsr;
  int          m_pre;

  function automatic int clamp16(int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int model_contrib(int i);
    int nd, amp;
    bit hi;
    nd = t_div[i];
    if (t_mode[i] == 3 || nd <= 1 || m_env[i] == 0) return 0;
    amp = t_vol[i] * 1024 * m_env[i] / 16;
    case (t_mode[i])
      0:       hi = (m_cnt[i] < nd / 2);
      1:       hi = (m_cnt[i] < nd / 8);
      default: hi = m_sign[i];
    endcase
    return hi ? amp : -amp;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_env[i] = 0; m_st[i] = 0; m_sign[i] = 1'b0;
    end
    m_lfsr = 16'hACE1;
    m_pre  = 0;
    sb.delete();
  endtask

  task automatic model_push();
    exp_t e;
    int   c, nd, st;
    bit   tk, wr, fb;
    e.l = 0; e.r = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = model_contrib(i);
      if (t_pan[i] != 2) e.l += c;
      if (t_pan[i] != 1) e.r += c;
    end
    e.l = clamp16(e.l);
    e.r = clamp16(e.r);
    sb.push_back(e);
    tk = (m_pre == ESD - 1);
    m_pre = tk ? 0 : m_pre + 1;
    for (int i = 0; i < NUM_CH; i++) begin
      nd = t_div[i];
      wr = (nd > 1) && (m_cnt[i] >= nd - 1);
      m_cnt[i] = (nd <= 1 || wr) ? 0 : m_cnt[i] + 1;
      if (wr) m_sign[i] = m_lfsr[15];
      st = m_st[i];
      case (st)
        0: if (t_gate[i]) st = 1;
        1: if (!t_gate[i]) st = 3; else if (m_env[i] == 15) st = 2;
        2: if (!t_gate[i]) st = 3;
        default: if (t_gate[i]) st = 1; else if (m_env[i] == 0) st = 0;
      endcase
      m_st[i] = st;
      if (tk) begin
        if (st == 1 && m_env[i] < 15) m_env[i]++;
        else if (st == 3 && m_env[i] > 0) m_env[i]--;
        else if (st == 2) m_env[i] = 15;
        else if (st == 0) m_env[i] = 0;
      end
    end
    fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
    m_lfsr = {m_lfsr[14:0], fb};
  endtask

  task automatic set_idle();
    for (int i = 0; i < NUM_CH; i++) begin
      t_div[i] = 100; t_mode[i] = 0; t_vol[i] = 7; t_pan[i] = 0; t_gate[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    int   lv, rv;
    set_idle();
    for (int i = 0; i < NUM_CH; i++) t_gate[i] = 1'b1;
    do_reset();
    for (int k = 0; k < 25; k++) begin
      model_push();
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if (audio_left !== 16'(e.l) || audio_right !== 16'(e.r)) begin
        mismatched++;
        $display("[TB] FAIL reset_attack k=%0d got %0d/%0d expected %0d/%0d", k, audio_left, audio_right, e.l, e.r);
      end
    end
    lv = audio_left; rv = audio_right;
    compared++;
    if (lv != 21504 || rv != 21504) begin
      mismatched++;
      $display("[TB] FAIL mid_attack_level got %0d/%0d expected 21504/21504", lv, rv);
    end
    #2 rst = 1'b0;
    model_reset();
    #1;
    lv = audio_left; rv = audio_right;
    compared++;
    if (lv != 0 || rv != 0) begin
      mismatched++;
      $display("[TB] FAIL async_reset got %0d/%0d expected 0/0", lv, rv);
    end
    repeat (2) @(posedge clk);
    #1;
    lv = audio_left; rv = audio_right;
    compared++;
    if (lv != 0 || rv != 0) begin
      mismatched++;
      $display("[TB] FAIL held_reset got %0d/%0d expected 0/0", lv, rv);
    end
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      model_push();
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if (audio_left !== 16'(e.l) || audio_right !== 16'(e.r)) begin
        mismatched++;
        $display("[TB] FAIL reset_restart k=%0d got %0d/%0d expected %0d/%0d", k, audio_left, audio_right, e.l, e.r);
      end
      lv = audio_left;
      if (k == 3 || k == 4) begin
        compared++;
        if (lv != ((k == 3) ? 0 : 3584)) begin
          mismatched++;
          $display("[TB] FAIL env_restart k=%0d got %0d expected %0d", k, lv, (k == 3) ? 0 : 3584);
        end
      end
    end
  endtask

  task automatic test_square(input int md, input int exp_pos, input string nm);
    exp_t e;
    int   lv, rv, pos, neg;
    pos = 0; neg = 0;
    set_idle();
    t_mode[0] = md;
    t_gate[0] = 1'b1;
    do_reset();
    for (int k = 0; k < 180; k++) begin
      model_push();
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if (audio_left !== 16'(e.l) || audio_right !== 16'(e.r)) begin
        mismatched++;
        $display("[TB] FAIL %s k=%0d got %0d/%0d expected %0d/%0d", nm, k, audio_left, audio_right, e.l, e.r);
      end
      lv = audio_left; rv = audio_right;
      if (k >= 80 && lv == 6720 && rv == 6720) pos++;
      if (k >= 80 && lv == -6720 && rv == -6720) neg++;
    end
    compared++;
    if (pos != exp_pos || neg != 100 - exp_pos) begin
      mismatched++;
      $display("[TB] FAIL %s_duty got +%0d/-%0d expected +%0d/-%0d", nm, pos, neg, exp_pos, 100 - exp_pos);
    end
  endtask

  task automatic test_rest_release();
    exp_t e;
    int   lv, nz, mag, prev, steps;
    nz = 0; steps = 0; prev = 6720;
    set_idle();
    t_gate[0] = 1'b1;
    do_reset();
    for (int k = 0; k < 200; k++) begin
      if (k == 80) t_div[0] = 1;
      if (k == 100) begin t_div[0] = 100; t_gate[0] = 1'b0; end
      if (k == 190) t_gate[0] = 1'b1;
      model_push();
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if (audio_left !== 16'(e.l) || audio_right !== 16'(e.r)) begin
        mismatched++;
        $display("[TB] FAIL rest_release k=%0d got %0d/%0d expected %0d/%0d", k, audio_left, audio_right, e.l, e.r);
      end
      lv  = audio_left;
      mag = (lv < 0) ? -lv : lv;
      if (k >= 80 && k < 100 && lv != 0) nz++;
      if (k >= 100 && k < 190 && mag != prev) begin
        steps++;
        compared++;
        if (prev - mag != 448) begin
          mismatched++;
          $display("[TB] FAIL release_step k=%0d got drop %0d expected 448", k, prev - mag);
        end
        prev = mag;
      end
    end
    compared++;
    if (nz != 0) begin
      mismatched++;
      $display("[TB] FAIL rest_silence got %0d nonzero expected 0", nz);
    end
    compared++;
    if (steps != 15 || prev != 0) begin
      mismatched++;
      $display("[TB] FAIL release_end got %0d steps mag %0d expected 15 steps mag 0", steps, prev);
    end
  endtask

  task automatic test_pan_sat();
    exp_t e;
    int   lv, rv, lp, ln, rp, rn, rnz, lmag;
    lp = 0; ln = 0; rp = 0; rn = 0; rnz = 0; lmag = 0;
    set_idle();
    for (int i = 0; i < NUM_CH; i++) t_gate[i] = 1'b1;
    do_reset();
    for (int k = 0; k < 380; k++) begin
      if (k == 180) t_pan[0] = 1;
      if (k == 280) for (int i = 1; i < NUM_CH; i++) t_gate[i] = 1'b0;
      model_push();
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if (audio_left !== 16'(e.l) || audio_right !== 16'(e.r)) begin
        mismatched++;
        $display("[TB] FAIL pan_sat k=%0d got %0d/%0d expected %0d/%0d", k, audio_left, audio_right, e.l, e.r);
      end
      lv = audio_left; rv = audio_right;
      if (k >= 80 && k < 180) begin
        if (lv == 32767) lp++;
        if (lv == -32768) ln++;
      end
      if (k >= 180 && k < 280) begin
        if (rv == 32767) rp++;
        if (rv == -32768) rn++;
      end
      if (k >= 360) begin
        if (rv != 0) rnz++;
        if (lv == 6720 || lv == -6720) lmag++;
      end
    end
    compared++;
    if (lp != 50 || ln != 50) begin
      mismatched++;
      $display("[TB] FAIL sat_both got +%0d/-%0d expected +50/-50", lp, ln);
    end
    compared++;
    if (rp != 50 || rn != 50) begin
      mismatched++;
      $display("[TB] FAIL sat_right_pan got +%0d/-%0d expected +50/-50", rp, rn);
    end
    compared++;
    if (rnz != 0 || lmag != 20) begin
      mismatched++;
      $display("[TB] FAIL left_only got right_nonzero=%0d left_full=%0d expected 0/20", rnz, lmag);
    end
  endtask

  task automatic test_noise();
    exp_t e;
    int   lv, prev, bad;
    bad = 0; prev = 0;
    set_idle();
    t_mode[0] = 2; t_div[0] = 50; t_gate[0] = 1'b1;
    t_mode[1] = 3; t_gate[1] = 1'b1;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      model_push();
      @(posedge clk); #1;
      e = sb.pop_front();
      compared++;
      if (audio_left !== 16'(e.l) || audio_right !== 16'(e.r)) begin
        mismatched++;
        $display("[TB] FAIL noise k=%0d got %0d/%0d expected %0d/%0d", k, audio_left, audio_right, e.l, e.r);
      end
      lv = audio_left;
      if (k > 70) begin
        if (lv != 6720 && lv != -6720) bad++;
        if (lv != prev && (k % 50) != 0) bad++;
      end
      prev = lv;
    end
    compared++;
    if (bad != 0) begin
      mismatched++;
      $display("[TB] FAIL noise_shape got %0d bad samples expected 0", bad);
    end
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    model_reset();
    test_reset();
    test_square(0, 50, "square50");
    test_square(1, 12, "square12");
    test_rest_release();
    test_pan_sat();
    test_noise();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/poly_note_gen.md
Name: poly_note_gen

Overview:
Parametrised multi-channel successor to the single-voice note generator. It turns NUM_CH independent note dividers into square (50%/12.5%) or noise voices, each with its own attack/sustain/release envelope, volume and pan. It mixes them into saturated signed 16-bit left/right samples for the audio DAC serializer. It sits between the music sequencer/keyboard logic and the speaker interface.

Parameters:
NUM_CH, 4, number of voices
DIV_W, 22, width of each note divider
ENV_STEP_DIV, 100_000, clk cycles per envelope step (1 kHz at 100 MHz)

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-low reset
note_div  in  NUM_CH*DIV_W  per-channel period in clk cycles; ch i at [i*DIV_W +: DIV_W]
gate  in  NUM_CH  per-channel key-on level
mode  in  2*NUM_CH  per channel: 00 square 50%, 01 square 12.5%, 10 noise, 11 mute
volume  in  3*NUM_CH  per-channel level 0..7
pan  in  2*NUM_CH  per channel: 00/11 both, 01 left only, 10 right only
audio_left  out  16  signed two's-complement sample, registered
audio_right  out  16  signed two's-complement sample, registered

Behaviour:
- Reset (rst=0, async): all phase counters 0, envelopes 0, env FSMs IDLE, prescaler 0, LFSR = 16'hACE1, audio_left/right = 0. Takes effect mid-note immediately.
- Phase counter per ch:
  - counts 0..note_div-1, then wraps to 0.
  - if note_div changes below the current count, wraps to 0 on the next clk.
  - note_div <= 1 is a rest: counter held at 0, contribution 0.
- High phase: cnt < (note_div>>1) in mode 00; cnt < (note_div>>3) in mode 01.
- Noise (mode 10):
  - shared Fibonacci LFSR, taps 16,14,13,11, advances every clk.
  - at each phase wrap the channel samples LFSR bit 15 into a held sign bit (1 = high).
- Amplitude: amp = (volume*1024*env) >> 4, unsigned, max 7168*15/16 = 6720. Contribution is +amp in high phase, -amp otherwise; 0 for mute, rest, or env=0.
- Envelope tick: shared prescaler counts 0..ENV_STEP_DIV-1 and emits a 1-cycle tick at wrap.
- Env FSM per ch, env 4-bit:
  - IDLE: env=0. gate=1 -> ATTACK.
  - ATTACK: +1 per tick. env=15 -> SUSTAIN. gate=0 -> RELEASE with env kept.
  - SUSTAIN: env=15 held. gate=0 -> RELEASE.
  - RELEASE: -1 per tick. env=0 -> IDLE. gate=1 -> ATTACK from current env.
  - Transitions are evaluated every clk. Level changes happen only on tick.
  - Tick and gate change in the same cycle: the transition applies and the step is taken in the new state.
- Mixer:
  - left sum = contributions with pan != 10; right sum = contributions with pan != 01.
  - sums are signed, sized clog2(NUM_CH)+17 bits.
  - each sum is saturated to [-32768, 32767] and registered.
  - latency: 1 clk from channel state to audio outputs.

Decomposition:
- Package note_pkg:
  - env state enum (IDLE/ATTACK/SUSTAIN/RELEASE)
  - mode codes and pan codes
  - LFSR seed 16'hACE1 and tap mask
  - VOL_STEP=1024, ENV_MAX=15
- Sub-module note_channel: phase counter, duty compare, noise sign hold, env FSM, amp/contribution output.
- Top level holds: prescaler, LFSR, generate loop of note_channel, pan-aware mixer with saturation.

Test Plan:
- Reset: drive gate=all 1, note_div=100, rst low mid-ATTACK -> outputs 0 the same cycle. Release rst -> env restarts from 0.
- Square 50%, ch0 only: ENV_STEP_DIV=4, note_div=100, vol=7, gate=1 -> env=15 after 60 clk. audio_left/right then alternate +6720 for 50 clk and -6720 for 50 clk.
- Duty 12.5%: same setup, mode=01 -> +6720 for 12 clk, -6720 for 88 clk per period.
- Rest and release: set note_div=1 -> output 0 despite gate. Restore 100, drop gate -> magnitude falls by 448 per tick, reaching 0 after 15 ticks with FSM in IDLE.
- Pan and saturation: NUM_CH=8, all vol 7, note_div=100, in phase, all pan 00 -> left/right clamp to +32767/-32768. Set ch0 pan=01 -> right high phase still saturates; with only ch0 active, right=0.
- Noise: mode=10, note_div=50 -> output is +/-6720, changes sign only at phase wraps, and matches a reference LFSR model cycle-exactly.
